// File: rtl/disp_mux_sched.sv
`default_nettype none
// ============================================================================
// Module      : disp_mux_sched
// Description : Scan scheduler that shares one hex-to-7-segment decoder
//               across NUM_DIGITS common-anode digits. Each digit gets a
//               dead time with every anode off (anti-ghosting), then its
//               nibble is latched for the decoder and its anode is driven.
//
// Ports       : clk        - system clock (6 MHz oscillator)
//               reset      - synchronous, active-low reset
//               en         - 1 = scan digits, 0 = hold all anodes off
//               digit_val  - packed nibbles, digit i = digit_val[4*i +: 4]
//               hex_sel    - nibble presented to the shared decoder
//               an_n       - active-low anode enables
//               slot       - index of the digit currently blanking/driving
//               frame_tick - one-cycle pulse after every digit was scanned
//
// Revision    : 1.0 - initial release
// ============================================================================
module disp_mux_sched #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 6000,
  parameter int BLANK_CYCLES = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digit_val,
  output logic [3:0]                    hex_sel,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] slot,
  output logic                          frame_tick
);

  localparam int c_CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_SLOT_W  = $clog2(NUM_DIGITS);

  localparam logic [c_CNT_W-1:0]  c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST  = c_SLOT_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Scheduler state
  state_t                r_state,     w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt,       w_cnt_nxt;
  logic [c_SLOT_W-1:0]   r_scan_slot, w_scan_slot_nxt;
  logic                  r_wrapped,   w_wrapped_nxt;

  // Registered outputs
  logic [3:0]            r_hex_sel,    w_hex_sel_nxt;
  logic [NUM_DIGITS-1:0] r_an_n,       w_an_n_nxt;
  logic [c_SLOT_W-1:0]   r_slot_out,   w_slot_out_nxt;
  logic                  r_frame_tick, w_frame_tick_nxt;

  logic [NUM_DIGITS-1:0] w_slot_onehot;
  logic [3:0]            w_cur_nibble;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
      assign w_slot_onehot[gi] = (r_scan_slot == c_SLOT_W'(gi));
    end
  endgenerate

  // Nibble of the digit currently owning the decoder
  always_comb begin
    w_cur_nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_slot_onehot[i]) begin
        w_cur_nibble = digit_val[4*i +: 4];
      end
    end
  end

  // Next-state and next-output logic. Outputs are computed from the state in
  // effect at the edge, so an_n and hex_sel switch on the same edge and the
  // decoder input can never move while an anode is on.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_scan_slot_nxt  = r_scan_slot;
    w_wrapped_nxt    = 1'b0;
    w_hex_sel_nxt    = r_hex_sel;
    w_an_n_nxt       = '1;
    w_slot_out_nxt   = r_scan_slot;
    w_frame_tick_nxt = 1'b0;

    if (!en) begin
      // Idle: restart the current slot from a full blank when re-enabled;
      // a pending frame pulse is dropped.
      w_state_nxt   = ST_BLANK;
      w_cnt_nxt     = '0;
      w_hex_sel_nxt = w_cur_nibble;
    end else begin
      case (r_state)
        ST_BLANK: begin
          w_hex_sel_nxt    = w_cur_nibble;
          w_frame_tick_nxt = r_wrapped;
          if (r_cnt == c_BLANK_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          w_an_n_nxt = ~w_slot_onehot;
          if (r_cnt == c_DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            if (r_scan_slot == c_SLOT_LAST) begin
              w_scan_slot_nxt = '0;
              w_wrapped_nxt   = 1'b1;
            end else begin
              w_scan_slot_nxt = r_scan_slot + c_SLOT_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_scan_slot  <= '0;
      r_wrapped    <= 1'b0;
      r_hex_sel    <= 4'h0;
      r_an_n       <= '1;
      r_slot_out   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_scan_slot  <= w_scan_slot_nxt;
      r_wrapped    <= w_wrapped_nxt;
      r_hex_sel    <= w_hex_sel_nxt;
      r_an_n       <= w_an_n_nxt;
      r_slot_out   <= w_slot_out_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end
  end

  assign hex_sel    = r_hex_sel;
  assign an_n       = r_an_n;
  assign slot       = r_slot_out;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_mux_sched
// Description : Self-checking bench for disp_mux_sched. A small instance
//               (2 digits, dwell 4, blank 2) is checked cycle by cycle
//               against a position-in-frame reference model and literal
//               timelines; a default-parameter instance is checked for the
//               scan invariants under random digit values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_mux_sched;

  localparam int TB_N     = 2;
  localparam int TB_DWELL = 4;
  localparam int TB_BLANK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic       s_reset = 1'b0;
  logic       s_en    = 1'b1;
  logic [7:0] s_dv    = 8'hA5;
  logic [3:0] s_hex;
  logic [1:0] s_an;
  logic [0:0] s_slot;
  logic       s_tick;

  // Default-parameter instance
  logic       b_reset = 1'b0;
  logic       b_en    = 1'b1;
  logic [7:0] b_dv    = 8'h00;
  logic [3:0] b_hex;
  logic [1:0] b_an;
  logic [0:0] b_slot;
  logic       b_tick;

  disp_mux_sched #(
    .NUM_DIGITS  (TB_N),
    .DWELL_CYCLES(TB_DWELL),
    .BLANK_CYCLES(TB_BLANK)
  ) u_small (
    .clk       (clk),
    .reset     (s_reset),
    .en        (s_en),
    .digit_val (s_dv),
    .hex_sel   (s_hex),
    .an_n      (s_an),
    .slot      (s_slot),
    .frame_tick(s_tick)
  );

  disp_mux_sched #(
    .NUM_DIGITS  (2),
    .DWELL_CYCLES(6000),
    .BLANK_CYCLES(60)
  ) u_big (
    .clk       (clk),
    .reset     (b_reset),
    .en        (b_en),
    .digit_val (b_dv),
    .hex_sel   (b_hex),
    .an_n      (b_an),
    .slot      (b_slot),
    .frame_tick(b_tick)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model for the small instance ----------------
  // Position within one digit's blank+dwell period, plus the scanned slot.
  int         m_pos  = 0;
  int         m_slot = 0;
  bit         m_pend = 1'b0;
  logic [1:0] e_an   = 2'b11;
  logic [3:0] e_hex  = 4'h0;
  logic [0:0] e_slot = 1'b0;
  logic       e_tick = 1'b0;

  function automatic logic [3:0] nib(input logic [7:0] dv, input int s);
    return dv[4*s +: 4];
  endfunction

  task automatic model_step();
    if (!s_reset) begin
      m_pos = 0; m_slot = 0; m_pend = 1'b0;
      e_an = 2'b11; e_hex = 4'h0; e_slot = 1'b0; e_tick = 1'b0;
    end else if (!s_en) begin
      e_an = 2'b11; e_hex = nib(s_dv, m_slot); e_slot = 1'(m_slot); e_tick = 1'b0;
      m_pos = 0; m_pend = 1'b0;
    end else begin
      e_slot = 1'(m_slot);
      e_tick = m_pend;
      m_pend = 1'b0;
      e_an   = 2'b11;
      if (m_pos < TB_BLANK) e_hex = nib(s_dv, m_slot);
      else                  e_an[m_slot] = 1'b0;
      m_pos++;
      if (m_pos == TB_BLANK + TB_DWELL) begin
        m_pos  = 0;
        m_slot = (m_slot + 1) % TB_N;
        m_pend = (m_slot == 0);
      end
    end
  endtask

  // ---------------- invariant monitor state for the big instance ----------
  bit         big_mon    = 1'b0;
  logic [1:0] prev_an    = 2'b11;
  logic [3:0] prev_hex   = 4'h0;
  bit         prev_on    = 1'b0;
  int         run        = 0;
  int         blank_run  = 0;
  int         last_tick  = 0;
  bit         tick_valid = 1'b0;
  bit         en_steady  = 1'b0;
  int         n_ticks    = 0;
  int         b_cyc      = 0;

  task automatic big_check(input bit en_s);
    bit cur_on;
    cur_on = (b_an != 2'b11);
    chk("big_one_anode", 32'($countones(~b_an) <= 1), 32'd1);
    if (cur_on && prev_on && b_an == prev_an) begin
      chk("big_hex_stable", 32'(b_hex), 32'(prev_hex));
      run++;
    end else begin
      if (prev_on && en_s) chk("big_dwell_len", 32'(run), 32'd6000);
      if (cur_on) begin
        chk("big_blank_len", 32'(blank_run >= 60), 32'd1);
        run = 1;
        blank_run = 0;
      end else begin
        blank_run++;
      end
    end
    if (b_tick) begin
      n_ticks++;
      if (tick_valid && en_steady) chk("big_tick_period", 32'(b_cyc - last_tick), 32'd12120);
      last_tick = b_cyc; tick_valid = 1'b1; en_steady = 1'b1;
    end
    if (!en_s) en_steady = 1'b0;
    prev_an = b_an; prev_hex = b_hex; prev_on = cur_on;
    b_cyc++;
  endtask

  // One clock: model sees the inputs the DUT samples, outputs checked 1 ns after.
  task automatic step();
    bit b_en_s;
    b_en_s = b_en;
    model_step();
    @(posedge clk);
    #1;
    chk("an_n", 32'(s_an), 32'(e_an));
    chk("hex_sel", 32'(s_hex), 32'(e_hex));
    chk("slot", 32'(s_slot), 32'(e_slot));
    chk("frame_tick", 32'(s_tick), 32'(e_tick));
    if (big_mon) big_check(b_en_s);
  endtask

  task automatic do_reset(input int n);
    s_reset = 1'b0;
    repeat (n) step();
    s_reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},   32'(s_an),   32'h3);
    chk({tag, "_hex"},  32'(s_hex),  32'h0);
    chk({tag, "_slot"}, 32'(s_slot), 32'h0);
    chk({tag, "_tick"}, 32'(s_tick), 32'h0);
  endtask

  // Literal timeline for digit_val=A5 from the first un-reset edge.
  task automatic run_a5_table(input string tag);
    logic [1:0] t_an   [13] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                               2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [3:0] t_hex  [13] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hA,
                               4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h5};
    logic       t_slot [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    for (int c = 0; c < 13; c++) begin
      step();
      chk({tag, "_an"},   32'(s_an),   32'(t_an[c]));
      chk({tag, "_hex"},  32'(s_hex),  32'(t_hex[c]));
      chk({tag, "_slot"}, 32'(s_slot), 32'(t_slot[c]));
      chk({tag, "_tick"}, 32'(s_tick), 32'(c == 12));
    end
  endtask

  initial begin
    int drop_len;

    // 1: reset values
    s_dv = 8'hA5; s_en = 1'b1;
    do_reset(3);
    chk_reset_vals("t1_reset");

    // 2: basic scan of A5
    run_a5_table("t2");

    // 3: digit_val change mid-dwell is ignored until the next blank
    do_reset(3);
    s_dv = 8'hA5;
    repeat (3) step();
    s_dv = 8'h3C;
    for (int c = 3; c <= 5; c++) begin
      step();
      chk("t3_hex_frozen", 32'(s_hex), 32'h5);
    end
    step();
    chk("t3_hex_new", 32'(s_hex), 32'h3);
    chk("t3_an_blank", 32'(s_an), 32'h3);

    // 4: en drop while slot 1 drives, then restart of that slot
    s_dv = 8'hA5;
    do_reset(3);
    repeat (9) step();
    chk("t4_an_c8", 32'(s_an), 32'h1);
    s_en = 1'b0;
    for (int c = 9; c <= 13; c++) begin
      step();
      chk("t4_off_an", 32'(s_an), 32'h3);
      chk("t4_off_slot", 32'(s_slot), 32'h1);
      chk("t4_off_tick", 32'(s_tick), 32'h0);
    end
    s_en = 1'b1;
    for (int c = 14; c <= 20; c++) begin
      step();
      if (c <= 15)      chk("t4_blank_an", 32'(s_an), 32'h3);
      else if (c <= 19) chk("t4_drive_an", 32'(s_an), 32'h1);
      else begin
        chk("t4_tick", 32'(s_tick), 32'h1);
        chk("t4_slot_wrap", 32'(s_slot), 32'h0);
      end
    end

    // 5: reset in the middle of a dwell
    do_reset(3);
    repeat (4) step();
    s_reset = 1'b0;
    step();
    chk_reset_vals("t5_reset");
    s_reset = 1'b1;
    run_a5_table("t5");

    // Random stimulus on the small instance against the model
    for (int i = 0; i < 2000; i++) begin
      s_dv    = 8'($urandom);
      s_en    = ($urandom_range(0, 9) != 0);
      s_reset = ($urandom_range(0, 49) != 0);
      step();
    end
    s_reset = 1'b1;
    s_en    = 1'b1;

    // 6: default-parameter instance, random digit values, one en outage
    big_mon = 1'b1;
    b_reset = 1'b0;
    repeat (2) step();
    b_reset = 1'b1;
    drop_len = $urandom_range(1, 300);
    for (int i = 0; i < 40000; i++) begin
      b_dv = 8'($urandom);
      s_dv = 8'($urandom);
      if (i == 25000) b_en = 1'b0;
      if (i == 25000 + drop_len) b_en = 1'b1;
      step();
    end
    chk("big_tick_seen", 32'(n_ticks >= 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
